// File: rtl/sram_copy_engine.sv
// sram_copy_engine: copies or fills a word region through one registered-read SRAM port, with a running XOR checksum
module sram_copy_engine #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [ADDRWIDTH-1:0]   src_addr,
  input  logic [ADDRWIDTH-1:0]   dst_addr,
  input  logic [ADDRWIDTH:0]     len,
  input  logic [DATAWIDTH-1:0]   fill_data,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [ADDRWIDTH:0]     words_done,
  output logic [DATAWIDTH-1:0]   checksum,
  output logic [ADDRWIDTH-1:0]   mem_addr,
  output logic                   mem_we,
  output logic [DATAWIDTH/8-1:0] mem_be,
  output logic [DATAWIDTH-1:0]   mem_d,
  input  logic [DATAWIDTH-1:0]   mem_q
);
  typedef enum logic [2:0] {IDLE, RD, WR, FILL, FIN} state_t;
  state_t                 state_q, state_d;
  logic [ADDRWIDTH:0]     i_q, i_d, len_q, len_d, wd_q, wd_d;
  logic [ADDRWIDTH-1:0]   src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [DATAWIDTH-1:0]   fill_q, fill_d, cs_q, cs_d, wdata;
  logic                   pend_q, pend_d, ab_q, ab_d, busy_q, busy_d, done_q, done_d, we_q, we_d, last;
  // Next state; every output register is derived from the next state so outputs line up with the state they describe
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    len_d   = len_q;
    wd_d    = wd_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    cs_d    = cs_q;
    pend_d  = pend_q;
    ab_d    = ab_q;
    wdata   = state_q == WR ? mem_q : fill_q;
    last    = (i_q + (ADDRWIDTH+1)'(1) == len_q) || abort || pend_q;
    if (state_q == IDLE && start) begin
      src_d   = src_addr;
      dst_d   = dst_addr;
      len_d   = len;
      fill_d  = fill_data;
      i_d     = '0;
      wd_d    = '0;
      cs_d    = '0;
      ab_d    = 1'b0;
      pend_d  = 1'b0;
      state_d = len == '0 ? FIN : mode ? FILL : RD;
    end else if (state_q == RD) begin
      pend_d  = pend_q | abort;
      state_d = WR;
    end else if (state_q == WR || state_q == FILL) begin
      i_d     = i_q + (ADDRWIDTH+1)'(1);
      wd_d    = wd_q + (ADDRWIDTH+1)'(1);
      cs_d    = cs_q ^ wdata;
      ab_d    = abort | pend_q;
      state_d = last ? FIN : state_q == WR ? RD : FILL;
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
    busy_d = state_d inside {RD, WR, FILL};
    done_d = state_d == FIN;
    we_d   = state_d inside {WR, FILL};
    addr_d = state_d == RD ? src_d + i_d[ADDRWIDTH-1:0] : we_d ? dst_d + i_d[ADDRWIDTH-1:0] : addr_q;
  end
  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      len_q   <= '0;
      wd_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      cs_q    <= '0;
      pend_q  <= 1'b0;
      ab_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      cs_q    <= cs_d;
      pend_q  <= pend_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = ab_q;
  assign words_done = wd_q;
  assign checksum   = cs_q;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_be     = {(DATAWIDTH/8){we_q}};
  assign mem_d      = state_q == WR ? mem_q : state_q == FILL ? fill_q : '0;
endmodule
